// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream block: FSM states, mode constants
// and the bitwise MSB-first CRC byte update.
package crc_pkg;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_APPEND = 1'b1
  } state_e;

  localparam int MODE_GEN = 0;
  localparam int MODE_CHK = 1;

  // Width-generic on a 32-bit carrier; bits above 'width' are kept at zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic [7:0]  data,
                                           input logic [31:0] poly,
                                           input int unsigned width);
    logic [31:0] c;
    logic [31:0] top;
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    top  = 32'd1 << (width - 1);
    c    = crc ^ (32'(data) << (width - 8));
    for (int i = 0; i < 8; i++) begin
      if ((c & top) != 32'd0) c = ((c << 1) ^ poly) & mask;
      else                    c = (c << 1) & mask;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Combinational one-byte CRC update; thin wrapper around crc_pkg::crc_step.
module crc_step_comb
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h07)
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] nxt
);

  assign nxt = CRC_W'(crc_step(32'(crc), data, 32'(POLY), CRC_W));

endmodule

// File: rtl/crc_stream.sv
// Byte-stream CRC generator (MODE=0, appends CRC) or checker (MODE=1).
// Optional statistics counters are built when CRC_STREAM_STATS_EN is defined.
module crc_stream
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter int               MODE    = MODE_GEN,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_clr,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  input  logic        i_ready,
  output logic        o_chk_valid,
  output logic        o_chk_err,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int NBYTES = CRC_W / 8;

  // Handshake: a beat moves on either side only in a cycle where its valid
  // and the matching ready are both high at the rising edge of i_clk.
  state_e           state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] crc_nxt;
  logic [CRC_W-1:0] shreg;
  logic [1:0]       cnt;
  logic             tail;
  logic             accept;
  logic             out_fire;

  crc_step_comb #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
    .crc  (crc),
    .data (i_data),
    .nxt  (crc_nxt)
  );

  assign o_ready  = (state == S_DATA) && (!o_valid || i_ready);
  assign accept   = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state       <= S_DATA;
      crc         <= INIT;
      shreg       <= '0;
      cnt         <= 2'd0;
      tail        <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_chk_valid <= 1'b0;
      o_chk_err   <= 1'b0;
    end else if (i_clr) begin
      state       <= S_DATA;
      crc         <= INIT;
      tail        <= 1'b0;
      o_valid     <= 1'b0;
      o_chk_valid <= 1'b0;
    end else begin
      o_chk_valid <= 1'b0;
      case (state)
        S_DATA: begin
          if (out_fire) o_valid <= 1'b0;
          if (accept) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
            o_last  <= (MODE == MODE_CHK) && i_last;
            if (!i_last) begin
              crc <= crc_nxt;
            end else begin
              crc <= INIT;
              if (MODE == MODE_GEN) begin
                shreg <= crc_nxt ^ XOROUT;
                cnt   <= 2'(NBYTES - 1);
                tail  <= 1'b0;
                state <= S_APPEND;
              end else begin
                o_chk_valid <= 1'b1;
                o_chk_err   <= (crc_nxt != RESIDUE);
              end
            end
          end
        end
        S_APPEND: begin
          // 'tail' means the final CRC byte is loaded and waiting for its handshake.
          if (tail) begin
            if (out_fire) begin
              o_valid <= 1'b0;
              tail    <= 1'b0;
              state   <= S_DATA;
            end
          end else if (!o_valid || i_ready) begin
            o_data  <= shreg[CRC_W-1 -: 8];
            o_valid <= 1'b1;
            o_last  <= (cnt == 2'd0);
            shreg   <= shreg << 8;
            if (cnt == 2'd0) tail <= 1'b1;
            else             cnt  <= cnt - 2'd1;
          end
        end
      endcase
    end
  end

`ifdef CRC_STREAM_STATS_EN
  logic        frame_done;
  logic        err_done;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  assign frame_done = (MODE == MODE_GEN) ? (state == S_APPEND && tail && out_fire && !i_clr)
                                         : o_chk_valid;
  assign err_done   = o_chk_valid && o_chk_err;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      frame_cnt <= 16'h0000;
      err_cnt   <= 16'h0000;
    end else begin
      if (frame_done && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (err_done && err_cnt != 16'hFFFF)     err_cnt   <= err_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt;
  assign o_err_cnt   = err_cnt;
`else
  assign o_frame_cnt = 16'h0000;
  assign o_err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: CRC-8/16/32 generators plus a CRC-16 checker,
// directed reference vectors followed by randomized frames against a bit-level model.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clr;
  logic [7:0]  in_data [4];
  logic        in_valid[4];
  logic        in_last [4];
  logic        in_ready[4];
  logic        out_ready[4];
  logic [7:0]  out_data [4];
  logic        out_valid[4];
  logic        out_last [4];
  logic        out_chk_valid[4];
  logic        out_chk_err[4];
  logic [15:0] frame_cnt[4];
  logic [15:0] err_cnt[4];

  int          cw[4]    = '{8, 16, 32, 16};
  logic [31:0] cpoly[4] = '{32'h07, 32'h1021, 32'h04C1_1DB7, 32'h1021};
  logic [31:0] cinit[4] = '{32'h00, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF};

`ifdef CRC_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int          n_pass;
  int          n_total;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        got_last_q[$];
  int          chk_cnt;
  logic        chk_err_val;
  int          exp_frames[4];
  int          exp_errs[4];

  always #5 clk = ~clk;

  crc_stream #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .MODE(0)) u_gen8 (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr),
    .i_data(in_data[0]), .i_valid(in_valid[0]), .i_last(in_last[0]), .o_ready(out_ready[0]),
    .o_data(out_data[0]), .o_valid(out_valid[0]), .o_last(out_last[0]), .i_ready(in_ready[0]),
    .o_chk_valid(out_chk_valid[0]), .o_chk_err(out_chk_err[0]),
    .o_frame_cnt(frame_cnt[0]), .o_err_cnt(err_cnt[0]));

  crc_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .MODE(0)) u_gen16 (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr),
    .i_data(in_data[1]), .i_valid(in_valid[1]), .i_last(in_last[1]), .o_ready(out_ready[1]),
    .o_data(out_data[1]), .o_valid(out_valid[1]), .o_last(out_last[1]), .i_ready(in_ready[1]),
    .o_chk_valid(out_chk_valid[1]), .o_chk_err(out_chk_err[1]),
    .o_frame_cnt(frame_cnt[1]), .o_err_cnt(err_cnt[1]));

  crc_stream #(.CRC_W(32), .POLY(32'h04C1_1DB7), .INIT(32'hFFFF_FFFF), .MODE(0)) u_gen32 (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr),
    .i_data(in_data[2]), .i_valid(in_valid[2]), .i_last(in_last[2]), .o_ready(out_ready[2]),
    .o_data(out_data[2]), .o_valid(out_valid[2]), .o_last(out_last[2]), .i_ready(in_ready[2]),
    .o_chk_valid(out_chk_valid[2]), .o_chk_err(out_chk_err[2]),
    .o_frame_cnt(frame_cnt[2]), .o_err_cnt(err_cnt[2]));

  crc_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .MODE(1), .RESIDUE(16'h0000)) u_chk16 (
    .i_clk(clk), .i_arst_n(arst_n), .i_clr(clr),
    .i_data(in_data[3]), .i_valid(in_valid[3]), .i_last(in_last[3]), .o_ready(out_ready[3]),
    .o_data(out_data[3]), .o_valid(out_valid[3]), .o_last(out_last[3]), .i_ready(in_ready[3]),
    .o_chk_valid(out_chk_valid[3]), .o_chk_err(out_chk_err[3]),
    .o_frame_cnt(frame_cnt[3]), .o_err_cnt(err_cnt[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sx(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Polynomial long division of the augmented message, INIT folded into its leading bits.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [7:0] msg[$]);
    bit          b[$];
    logic [31:0] r;
    int          nbits;
    nbits = msg.size() * 8;
    foreach (msg[i]) for (int k = 7; k >= 0; k--) b.push_back(msg[i][k]);
    for (int k = 0; k < w; k++) b.push_back(1'b0);
    for (int k = 0; k < w; k++) b[k] = b[k] ^ init[w-1-k];
    for (int i = 0; i < nbits; i++) begin
      if (b[i]) begin
        b[i] = 1'b0;
        for (int j = 1; j <= w; j++) b[i+j] = b[i+j] ^ poly[w-j];
      end
    end
    r = 32'd0;
    for (int k = 0; k < w; k++) r[w-1-k] = b[nbits+k];
    return r;
  endfunction

  task automatic make_exp_gen(input int d, input logic [7:0] msg[$]);
    logic [31:0] c;
    c = ref_crc(cw[d], cpoly[d], cinit[d], msg);
    exp_q = msg;
    for (int k = cw[d]/8 - 1; k >= 0; k--) exp_q.push_back(c[k*8 +: 8]);
  endtask

  // Drives one frame into instance d; n_send < msg.size() sends only a prefix.
  task automatic run_frame(input int d, input logic [7:0] msg[$], input int n_send,
                           input int stall_at, input int stall_len, input bit rnd);
    int         sent = 0;
    int         cyc = 0;
    bit         done = 0;
    bit         last_seen = 0;
    bit         was_stalled = 0;
    logic [7:0] held = 8'h00;
    got_q.delete();
    got_last_q.delete();
    chk_cnt = 0;
    chk_err_val = 1'b0;
    while (!done && cyc < 600) begin
      in_valid[d] = (sent < n_send) && (!rnd || $urandom_range(0, 3) != 0);
      in_data[d]  = (sent < n_send) ? msg[sent] : 8'h00;
      in_last[d]  = (sent == msg.size() - 1);
      in_ready[d] = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                    (!rnd || $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (was_stalled) begin
        chk("hold_valid", 32'(out_valid[d]), 32'd1);
        chk("hold_data", 32'(out_data[d]), 32'(held));
      end
      if (out_valid[d] && in_ready[d]) begin
        got_q.push_back(out_data[d]);
        got_last_q.push_back(out_last[d]);
        if (out_last[d]) last_seen = 1;
      end
      if (out_chk_valid[d]) begin
        chk_cnt++;
        chk_err_val = out_chk_err[d];
      end
      if (in_valid[d] && out_ready[d]) sent++;
      was_stalled = out_valid[d] && !in_ready[d];
      held = out_data[d];
      if (n_send < msg.size()) done = (sent == n_send);
      else if (d == 3)         done = last_seen && (chk_cnt > 0);
      else                     done = last_seen;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    in_ready[d] = 1'b1;
    chk("frame_done", 32'(done), 32'd1);
    if (d == 3 && done && n_send == msg.size()) begin
      @(negedge clk);
      chk("chk_pulse_width", 32'(out_chk_valid[d]), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk($sformatf("%s_last%0d", tag, i), 32'(got_last_q[i]), 32'(i == exp_q.size() - 1));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  msg[$];
    logic [7:0]  full[$];
    logic [31:0] c;
    int          len;
    int          bitpos;
    bit          bad;

    n_pass = 0;
    n_total = 0;
    arst_n = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 8'h00; in_last[i] = 1'b0; in_ready[i] = 1'b1;
      exp_frames[i] = 0; exp_errs[i] = 0;
    end
    for (int i = 0; i < 9; i++) msg.push_back(8'(8'h31 + i));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rst_last%0d", i), 32'(out_last[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(out_data[i]), 32'd0);
      chk($sformatf("rst_chkv%0d", i), 32'(out_chk_valid[i]), 32'd0);
      chk($sformatf("rst_chke%0d", i), 32'(out_chk_err[i]), 32'd0);
      chk($sformatf("rst_fcnt%0d", i), 32'(frame_cnt[i]), 32'd0);
      chk($sformatf("rst_ecnt%0d", i), 32'(err_cnt[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(out_ready[i]), 32'd1);
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    // (a) CRC-8, init 00
    exp_q = msg; exp_q.push_back(8'hF4);
    run_frame(0, msg, 9, -1, 0, 0);
    compare_out("a");
    exp_frames[0]++;

    // (b) CRC-16/CCITT-FALSE
    exp_q = msg; exp_q.push_back(8'h29); exp_q.push_back(8'hB1);
    run_frame(1, msg, 9, -1, 0, 0);
    compare_out("b");
    exp_frames[1]++;

    // (e) same as (b) with output stalled while the first CRC byte is presented
    run_frame(1, msg, 9, 10, 5, 0);
    compare_out("e");
    exp_frames[1]++;
    chk("e_fcnt", 32'(frame_cnt[1]), sx(exp_frames[1]));

    // (c) CRC-32/MPEG-2
    exp_q = msg;
    exp_q.push_back(8'h03); exp_q.push_back(8'h76); exp_q.push_back(8'hE6); exp_q.push_back(8'hE7);
    run_frame(2, msg, 9, -1, 0, 0);
    compare_out("c");
    exp_frames[2]++;

    // (d) check mode on the (b) output, then with byte 3 corrupted
    full = msg; full.push_back(8'h29); full.push_back(8'hB1);
    exp_q = full;
    run_frame(3, full, 11, -1, 0, 0);
    compare_out("d_good");
    chk("d_good_valid", 32'(chk_cnt), 32'd1);
    chk("d_good_err", 32'(chk_err_val), 32'd0);
    exp_frames[3]++;
    full[2] = full[2] ^ 8'h04;
    exp_q = full;
    run_frame(3, full, 11, -1, 0, 0);
    compare_out("d_bad");
    chk("d_bad_valid", 32'(chk_cnt), 32'd1);
    chk("d_bad_err", 32'(chk_err_val), 32'd1);
    exp_frames[3]++;
    exp_errs[3]++;
    chk("d_errcnt", 32'(err_cnt[3]), sx(exp_errs[3]));
    chk("d_fcnt", 32'(frame_cnt[3]), sx(exp_frames[3]));

    // (f) abort with i_clr after byte 4; the beat offered with i_clr must be dropped
    run_frame(0, msg, 4, -1, 0, 0);
    clr = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = 8'h55; in_last[0] = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    @(negedge clk);
    chk("f_clr_valid", 32'(out_valid[0]), 32'd0);
    chk("f_clr_ready", 32'(out_ready[0]), 32'd1);
    @(posedge clk); #1;
    exp_q = msg; exp_q.push_back(8'hF4);
    run_frame(0, msg, 9, -1, 0, 0);
    compare_out("f_clr");
    exp_frames[0]++;
    chk("f_clr_fcnt", 32'(frame_cnt[0]), sx(exp_frames[0]));

    // (f) abort with asynchronous reset after byte 4
    run_frame(0, msg, 4, -1, 0, 0);
    #2;
    arst_n = 1'b0;
    @(negedge clk);
    chk("f_rst_valid", 32'(out_valid[0]), 32'd0);
    chk("f_rst_fcnt", 32'(frame_cnt[1]), 32'd0);
    chk("f_rst_ecnt", 32'(err_cnt[3]), 32'd0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin exp_frames[i] = 0; exp_errs[i] = 0; end
    @(posedge clk); #1;
    exp_q = msg; exp_q.push_back(8'hF4);
    run_frame(0, msg, 9, -1, 0, 0);
    compare_out("f_rst");
    exp_frames[0]++;

    // Randomized generator frames with random valid/ready gaps
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 3; d++) begin
        msg.delete();
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
        make_exp_gen(d, msg);
        run_frame(d, msg, len, -1, 0, 1);
        compare_out($sformatf("rnd_gen%0d_%0d", d, r));
        exp_frames[d]++;
      end
    end

    // Randomized checker frames, every other one with a single flipped bit
    for (int r = 0; r < 6; r++) begin
      msg.delete();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      c = ref_crc(16, cpoly[3], cinit[3], msg);
      full = msg; full.push_back(c[15:8]); full.push_back(c[7:0]);
      bad = (r % 2) == 1;
      if (bad) begin
        bitpos = $urandom_range(0, full.size() * 8 - 1);
        full[bitpos/8] = full[bitpos/8] ^ 8'(1 << (bitpos % 8));
      end
      exp_q = full;
      run_frame(3, full, full.size(), -1, 0, 1);
      compare_out($sformatf("rnd_chk%0d", r));
      chk($sformatf("rnd_chk%0d_valid", r), 32'(chk_cnt), 32'd1);
      chk($sformatf("rnd_chk%0d_err", r), 32'(chk_err_val), 32'(bad));
      exp_frames[3]++;
      if (bad) exp_errs[3]++;
    end

    // Statistics totals
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("end_fcnt%0d", i), 32'(frame_cnt[i]), sx(exp_frames[i]));
      chk($sformatf("end_ecnt%0d", i), 32'(err_cnt[i]), sx(exp_errs[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
